serial_word_assembler: RTL and testbench
========================================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the assembled word width (SIZE >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in DOUT[SIZE-1], 0 = first received bit lands in DOUT[0].
REQ-003 SHALL have port CLK, input, 1 bit: module clock; all state updates on its rising edge.
REQ-004 SHALL have port SR, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port SSTART, input, 1 bit: frame start strobe.
REQ-006 SHALL have port SVALID, input, 1 bit: SIN qualifier; a bit is consumed only on a cycle with SVALID=1.
REQ-007 SHALL have port SIN, input, 1 bit: serial data bit.
REQ-008 SHALL have port DOUT, output, SIZE bits: last good assembled word; drives a downstream register's DIN.
REQ-009 SHALL have port CE_OUT, output, 1 bit: one-cycle pulse marking a new DOUT; drives the downstream register's CE.
REQ-010 SHALL have port BUSY, output, 1 bit: high while a frame is in progress (SHIFT or PARITY state).
REQ-011 SHALL have port PERR, output, 1 bit: sticky parity-error flag.
REQ-012 SHALL have port ERRCNT, output, 8 bits: saturating count of parity-failed frames.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PARITY and DONE.
REQ-014 IDLE SHALL move to SHIFT on SSTART=1, clearing the bit counter and shift register; SVALID and SIN on the SSTART cycle SHALL be ignored.
REQ-015 SHIFT SHALL, on each SVALID=1 cycle, shift SIN into the shift register per MSB_FIRST and increment the bit counter; SVALID=0 cycles SHALL hold all state (gaps allowed, no timeout).
REQ-016 SHIFT SHALL move to PARITY on the edge consuming bit SIZE (counter reaching SIZE-1 with SVALID=1).
REQ-017 PARITY SHALL, on SVALID=1, check even parity: XOR of the SIZE data bits and SIN must equal 0.
REQ-018 On a parity match, the FSM SHALL load DOUT with the shift register and go to DONE on the same edge.
REQ-019 On a parity mismatch, the FSM SHALL set PERR=1, increment ERRCNT (saturating at 255), leave DOUT unchanged and return to IDLE.
REQ-020 DONE SHALL assert CE_OUT=1 for exactly that one cycle and return to IDLE unconditionally; CE_OUT SHALL be 0 in every other state.
REQ-021 Latency: CE_OUT SHALL be high in the cycle immediately after the edge that sampled the parity bit, with DOUT already holding the new word.
REQ-022 SSTART=1 in SHIFT or PARITY SHALL abort the current frame and restart it (counter and shift register cleared, stay/enter SHIFT); DOUT SHALL be unchanged and no error SHALL be counted.
REQ-023 SSTART=1 in DONE SHALL still let CE_OUT pulse, and the FSM SHALL go directly to SHIFT.
REQ-024 SSTART and a valid parity bit arriving on the same edge: SSTART SHALL win (abort, no DOUT load, no error).
REQ-025 PERR SHALL be cleared only by SR; a later good frame SHALL NOT clear it.
REQ-026 DOUT SHALL hold its value between good frames; partially assembled bits SHALL never appear on DOUT.

Reset
REQ-027 SR=1 SHALL asynchronously force state=IDLE, DOUT=0, CE_OUT=0, BUSY=0, PERR=0, ERRCNT=0, bit counter=0 and shift register=0, regardless of CLK.
REQ-028 SR asserted mid-frame SHALL discard the partial frame; after SR deasserts, the block SHALL wait in IDLE for SSTART.

Verification (SIZE=8)
REQ-029 Good frame, MSB_FIRST=1: SSTART, bits 1,0,1,0,0,1,0,1 then parity 0 -> DOUT=0xA5, CE_OUT high for 1 cycle, PERR=0.
REQ-030 Bad parity: same 0xA5 bits with parity 1 -> CE_OUT stays 0, DOUT keeps its prior value, PERR=1, ERRCNT=1.
REQ-031 Gapped input: 0x3C sent with SVALID=0 for 3 cycles between every bit, parity 0 -> DOUT=0x3C, exactly one CE_OUT pulse.
REQ-032 Restart: SSTART after 4 bits, then a full 0x81 frame with parity 0 -> DOUT=0x81, ERRCNT unchanged, one CE_OUT pulse.
REQ-033 Async reset: SR pulsed between clock edges after 5 bits -> all outputs 0 immediately; the next full 0xFF frame with parity 0 -> DOUT=0xFF.
REQ-034 LSB-first and saturation: MSB_FIRST=0 with bits 1,0,1,0,0,0,0,0 and parity 0 -> DOUT=0x05; then 300 bad-parity frames -> ERRCNT=255.

Source files
------------

// File: rtl/serial_word_assembler_if.sv
// Serial word assembler bus: frame/bit inputs from the serial source and
// the assembled-word outputs toward the downstream register.
interface serial_word_assembler_if #(
   parameter int SIZE = 8
);
   logic            SSTART;
   logic            SVALID;
   logic            SIN;
   logic [SIZE-1:0] DOUT;
   logic            CE_OUT;
   logic            BUSY;
   logic            PERR;
   logic [7:0]      ERRCNT;

   modport master (
      output SSTART, SVALID, SIN,
      input  DOUT, CE_OUT, BUSY, PERR, ERRCNT
   );

   modport slave (
      input  SSTART, SVALID, SIN,
      output DOUT, CE_OUT, BUSY, PERR, ERRCNT
   );
endinterface

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with trailing even-parity check.
// A frame is SSTART, SIZE qualified data bits, then one qualified parity bit.
// Good frames load DOUT and pulse CE_OUT; bad frames bump a saturating error
// count and set a sticky error flag without touching DOUT.
//
// state  | meaning
// IDLE   | waiting for SSTART
// SHIFT  | collecting SIZE data bits (SVALID-qualified, gaps allowed)
// PARITY | waiting for the qualified parity bit
// DONE   | CE_OUT pulse cycle for a freshly loaded DOUT
module serial_word_assembler #(
   parameter int SIZE      = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                    CLK,
   input logic                    SR,
   serial_word_assembler_if.slave bus
);

   localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] sh_q, sh_d;
   logic [SIZE-1:0] dout_q, dout_d;
   logic            ce_q, ce_d;
   logic            busy_q, busy_d;
   logic            perr_q, perr_d;
   logic [7:0]      errcnt_q, errcnt_d;

   logic [SIZE-1:0] sh_shifted;
   logic            parity_ok;

   // Shift direction fixed by MSB_FIRST: first bit ends up in the MSB or LSB.
   always_comb begin
      if (MSB_FIRST) begin
         sh_shifted = {sh_q[SIZE-2:0], bus.SIN};
      end else begin
         sh_shifted = {bus.SIN, sh_q[SIZE-1:1]};
      end
      parity_ok = ~((^sh_q) ^ bus.SIN);
   end

   // Next-state and next-output decode; SSTART always takes priority over data.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      dout_d   = dout_q;
      ce_d     = 1'b0;
      busy_d   = busy_q;
      perr_d   = perr_q;
      errcnt_d = errcnt_q;

      case (state_q)
         IDLE: begin
            if (bus.SSTART) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sh_d    = '0;
               busy_d  = 1'b1;
            end
         end

         SHIFT: begin
            if (bus.SSTART) begin
               cnt_d = '0;
               sh_d  = '0;
            end else if (bus.SVALID) begin
               sh_d = sh_shifted;
               if (cnt_q == CW'(SIZE - 1)) begin
                  state_d = PARITY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         PARITY: begin
            if (bus.SSTART) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sh_d    = '0;
            end else if (bus.SVALID) begin
               busy_d = 1'b0;
               if (parity_ok) begin
                  state_d = DONE;
                  dout_d  = sh_q;
                  ce_d    = 1'b1;
               end else begin
                  state_d = IDLE;
                  perr_d  = 1'b1;
                  if (errcnt_q != 8'hFF) begin
                     errcnt_d = errcnt_q + 8'd1;
                  end
               end
            end
         end

         DONE: begin
            if (bus.SSTART) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sh_d    = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; SR clears everything immediately.
   always_ff @(posedge CLK or posedge SR) begin
      if (SR) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         dout_q   <= '0;
         ce_q     <= 1'b0;
         busy_q   <= 1'b0;
         perr_q   <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         dout_q   <= dout_d;
         ce_q     <= ce_d;
         busy_q   <= busy_d;
         perr_q   <= perr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign bus.DOUT   = dout_q;
   assign bus.CE_OUT = ce_q;
   assign bus.BUSY   = busy_q;
   assign bus.PERR   = perr_q;
   assign bus.ERRCNT = errcnt_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: instance A is MSB-first, instance B is
// LSB-first. Good words on A are queued when the parity bit is driven and
// popped when CE_OUT is seen.
module tb_serial_word_assembler;

   logic CLK = 1'b0;
   logic SR  = 1'b0;

   always #5 CLK = ~CLK;

   serial_word_assembler_if #(.SIZE(8)) ifa ();
   serial_word_assembler_if #(.SIZE(8)) ifb ();

   serial_word_assembler #(.SIZE(8), .MSB_FIRST(1'b1)) dut_a (
      .CLK (CLK),
      .SR  (SR),
      .bus (ifa)
   );

   serial_word_assembler #(.SIZE(8), .MSB_FIRST(1'b0)) dut_b (
      .CLK (CLK),
      .SR  (SR),
      .bus (ifb)
   );

   typedef struct {
      logic [7:0] word;
      logic       par;
      int         gap;
      logic       good;
   } vec_t;

   int         checks      = 0;
   int         failures    = 0;
   int         ce_seen     = 0;
   int         ce_expected = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_dout    = 8'h00;
   logic       exp_perr    = 1'b0;
   int         exp_errcnt  = 0;
   vec_t       vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit sel, input logic s, input logic v, input logic d);
      if (!sel) begin
         ifa.SSTART = s; ifa.SVALID = v; ifa.SIN = d;
      end else begin
         ifb.SSTART = s; ifb.SVALID = v; ifb.SIN = d;
      end
   endtask

   task automatic start(input bit sel);
      drive(sel, 1'b1, 1'b0, 1'b0);
      tick();
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   // Sends n data bits; A sends word MSB first, B sends it LSB first.
   task automatic bits(input bit sel, input logic [7:0] word, input int n, input int gap);
      logic [7:0] w;
      w = word;
      for (int i = 0; i < n; i++) begin
         drive(sel, 1'b0, 1'b1, sel ? w[i] : w[7-i]);
         tick();
         drive(sel, 1'b0, 1'b0, 1'b0);
         repeat (gap) tick();
      end
   endtask

   // Parity bit on A with model update; checks the CE_OUT latency.
   task automatic parity_a(input logic [7:0] word, input logic par, input logic good);
      drive(1'b0, 1'b0, 1'b1, par);
      if (good) begin
         exp_q.push_back(word);
         ce_expected++;
         exp_dout = word;
      end else begin
         exp_perr = 1'b1;
         if (exp_errcnt < 255) exp_errcnt++;
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ce_after_parity", 32'(ifa.CE_OUT), 32'(good));
      chk("dout_after_parity", 32'(ifa.DOUT), 32'(exp_dout));
   endtask

   task automatic check_a_idle(input string tag);
      chk({tag, "_ce"},     32'(ifa.CE_OUT), 32'd0);
      chk({tag, "_busy"},   32'(ifa.BUSY),   32'd0);
      chk({tag, "_dout"},   32'(ifa.DOUT),   32'(exp_dout));
      chk({tag, "_perr"},   32'(ifa.PERR),   32'(exp_perr));
      chk({tag, "_errcnt"}, 32'(ifa.ERRCNT), 32'(exp_errcnt));
   endtask

   // Scoreboard: every CE_OUT pulse on A must match the oldest queued word.
   always @(negedge CLK) begin
      if (ifa.CE_OUT === 1'b1) begin
         ce_seen++;
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_ce", 32'd1, 32'd0);
         end else begin
            chk("sb_dout", 32'(ifa.DOUT), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{word: 8'hA5, par: 1'b0, gap: 0, good: 1'b1};
      vecs[1] = '{word: 8'hA5, par: 1'b1, gap: 0, good: 1'b0};
      vecs[2] = '{word: 8'h3C, par: 1'b0, gap: 3, good: 1'b1};
      vecs[3] = '{word: 8'hC3, par: 1'b1, gap: 1, good: 1'b0};
      vecs[4] = '{word: 8'h7E, par: 1'b0, gap: 0, good: 1'b1};
      vecs[5] = '{word: 8'h01, par: 1'b1, gap: 2, good: 1'b1};

      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1 SR = 1'b1;
      #2;
      check_a_idle("reset");
      chk("reset_b_dout", 32'(ifb.DOUT), 32'd0);
      repeat (2) @(posedge CLK);
      #1 SR = 1'b0;
      tick();

      // Table-driven frames on A, including gapped and bad-parity cases.
      for (int i = 0; i < 6; i++) begin
         start(1'b0);
         chk("busy_in_frame", 32'(ifa.BUSY), 32'd1);
         bits(1'b0, vecs[i].word, 8, vecs[i].gap);
         parity_a(vecs[i].word, vecs[i].par, vecs[i].good);
         tick();
         check_a_idle("vec");
      end

      // Restart after 4 bits, then a full 0x81 frame.
      start(1'b0);
      bits(1'b0, 8'hF0, 4, 0);
      start(1'b0);
      bits(1'b0, 8'h81, 8, 0);
      parity_a(8'h81, 1'b0, 1'b1);
      tick();
      check_a_idle("restart");

      // SSTART on the same edge as a valid parity bit: abort wins.
      start(1'b0);
      bits(1'b0, 8'hA5, 8, 0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sstart_vs_parity_ce",   32'(ifa.CE_OUT), 32'd0);
      chk("sstart_vs_parity_busy", 32'(ifa.BUSY),   32'd1);
      chk("sstart_vs_parity_dout", 32'(ifa.DOUT),   32'(exp_dout));
      chk("sstart_vs_parity_err",  32'(ifa.ERRCNT), 32'(exp_errcnt));
      bits(1'b0, 8'h5A, 8, 0);
      parity_a(8'h5A, 1'b0, 1'b1);

      // SSTART during DONE: CE_OUT already high, FSM goes straight to SHIFT.
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_sstart_busy", 32'(ifa.BUSY),   32'd1);
      chk("done_sstart_ce",   32'(ifa.CE_OUT), 32'd0);
      bits(1'b0, 8'h34, 8, 0);
      parity_a(8'h34, 1'b1, 1'b1);
      tick();
      check_a_idle("done_sstart");

      // Async reset between edges after 5 bits.
      start(1'b0);
      bits(1'b0, 8'hE7, 5, 0);
      #2 SR = 1'b1;
      #1;
      exp_dout = 8'h00; exp_perr = 1'b0; exp_errcnt = 0;
      check_a_idle("async_rst");
      #2 SR = 1'b0;
      tick();
      bits(1'b0, 8'hFF, 8, 0);
      chk("post_rst_no_start_busy", 32'(ifa.BUSY), 32'd0);
      chk("post_rst_no_start_dout", 32'(ifa.DOUT), 32'd0);
      start(1'b0);
      bits(1'b0, 8'hFF, 8, 0);
      parity_a(8'hFF, 1'b0, 1'b1);
      tick();
      check_a_idle("post_rst");

      // LSB-first instance: 1,0,1,0,0,0,0,0 then parity 0 gives 0x05.
      start(1'b1);
      bits(1'b1, 8'h05, 8, 0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("lsb_ce",   32'(ifb.CE_OUT), 32'd1);
      chk("lsb_dout", 32'(ifb.DOUT),   32'h05);
      tick();
      chk("lsb_ce_single", 32'(ifb.CE_OUT), 32'd0);

      // 300 bad-parity frames on B: ERRCNT saturates at 255.
      for (int i = 0; i < 300; i++) begin
         start(1'b1);
         bits(1'b1, 8'h05, 8, 0);
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         tick();
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 253) chk("errcnt_254", 32'(ifb.ERRCNT), 32'd254);
      end
      chk("errcnt_sat",    32'(ifb.ERRCNT), 32'd255);
      chk("sat_perr",      32'(ifb.PERR),   32'd1);
      chk("sat_dout_kept", 32'(ifb.DOUT),   32'h05);

      tick();
      chk("sb_ce_count", 32'(ce_seen), 32'(ce_expected));
      chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
